// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length byte, then N big-endian
// 32-bit words as a byte stream, writes each word into instruction memory,
// and finally releases the CPU. Optional checksum byte verification is
// compiled in with the macro IMEM_LOADER_CHECKSUM_EN.
module imem_loader (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_start_o,
    output logic        done_o,
    output logic        err_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;
`endif

    state_t      r_state;
    state_t      w_nextState;
    logic [8:0]  r_count;
    logic [7:0]  r_wordIdx;
    logic [1:0]  r_byteCnt;
    logic [23:0] r_partial;
    logic        r_we;
    logic [7:0]  r_addr;
    logic [31:0] r_data;
    logic        r_cpuStart;
    logic        r_done;
    logic        w_ready;
    logic        w_accept;
    logic        w_wordDone;
    logic        w_lastWord;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
    logic        r_err;
`endif

    // State register; a low start_i forces the loader back to waiting for a length byte.
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            r_state <= S_LEN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the handshake and word-completion strobes.
    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        w_wordDone  = 1'b0;
        w_lastWord  = ({1'b0, r_wordIdx} == (r_count - 9'd1));
        case (r_state)
            S_LEN:  w_ready = 1'b1;
            S_DATA: w_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: w_ready = 1'b1;
`endif
            default: w_ready = 1'b0;
        endcase
        w_accept = valid_i & w_ready;
        case (r_state)
            S_LEN: begin
                if (w_accept) begin
                    w_nextState = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && (r_byteCnt == 2'd3)) begin
                    w_wordDone = 1'b1;
                    if (w_lastWord) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_nextState = S_CSUM;
`else
                        w_nextState = S_RUN;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_accept) begin
                    w_nextState = (data_i == r_csum) ? S_RUN : S_ERR;
                end
            end
`endif
            default: w_nextState = r_state;
        endcase
    end

    // Datapath: length capture, word assembly, memory write port and status flags.
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            r_count    <= 9'd0;
            r_wordIdx  <= 8'd0;
            r_byteCnt  <= 2'd0;
            r_partial  <= 24'd0;
            r_we       <= 1'b0;
            r_addr     <= 8'd0;
            r_data     <= 32'd0;
            r_cpuStart <= 1'b0;
            r_done     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_we <= w_wordDone;
            if ((r_state == S_LEN) && w_accept) begin
                r_count <= (data_i == 8'd0) ? 9'd256 : {1'b0, data_i};
            end
            if ((r_state == S_DATA) && w_accept) begin
                r_byteCnt <= r_byteCnt + 2'd1;
                r_partial <= {r_partial[15:0], data_i};
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_csum    <= r_csum ^ data_i;
`endif
            end
            if (w_wordDone) begin
                r_addr <= r_wordIdx;
                r_data <= {r_partial, data_i};
                if (!w_lastWord) begin
                    r_wordIdx <= r_wordIdx + 8'd1;
                end
            end
            r_cpuStart <= (w_nextState == S_RUN);
            r_done     <= (w_nextState == S_RUN);
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_err      <= (w_nextState == S_ERR);
`endif
        end
    end

    assign ready_o     = w_ready;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_data_o  = r_data;
    assign cpu_start_o = r_cpuStart;
    assign done_o      = r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err_o       = r_err;
`else
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Builds byte streams, drives them with
// optional idle gaps, and compares the observed memory writes and status flags
// against writes and outcomes derived from the stream contents. Follows the
// IMEM_LOADER_CHECKSUM_EN macro so the same bench covers both builds.
module tb_imem_loader;

    logic        clk_i = 1'b0;
    logic        start_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic        mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic        cpu_start_o;
    logic        done_o;
    logic        err_o;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  streamQ[$];
    logic [39:0] expQ[$];
    logic [39:0] obsQ[$];
    bit          expOk;
    int          readyLow;
    int          earlyStatus;

    imem_loader dut (
        .clk_i       (clk_i),
        .start_i     (start_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .cpu_start_o (cpu_start_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    // Record every memory write strobe seen between active edges.
    always @(negedge clk_i) begin
        if (mem_we_o === 1'b1) begin
            obsQ.push_back({mem_addr_o, mem_data_o});
        end
    end

    task automatic waitEdge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        valid_i = 1'b0;
        repeat (gap) waitEdge();
        data_i  = b;
        valid_i = 1'b1;
        if (ready_o !== 1'b1) readyLow++;
        waitEdge();
        valid_i = 1'b0;
    endtask

    task automatic doReset();
        start_i = 1'b0;
        valid_i = 1'b0;
        waitEdge();
        start_i = 1'b1;
        obsQ.delete();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".ready"},   ready_o,     1);
        checkOutput({tag, ".we"},      mem_we_o,    0);
        checkOutput({tag, ".addr"},    mem_addr_o,  0);
        checkOutput({tag, ".data"},    mem_data_o,  0);
        checkOutput({tag, ".cpu"},     cpu_start_o, 0);
        checkOutput({tag, ".done"},    done_o,      0);
        checkOutput({tag, ".err"},     err_o,       0);
    endtask

    // Appends the checksum byte (only when the feature is built); corrupt flips it.
    task automatic addChecksum(input bit corrupt);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
        for (int i = 1; i < streamQ.size(); i++) x = x ^ streamQ[i];
        if (corrupt) x = x ^ 8'($urandom_range(255, 1));
        streamQ.push_back(x);
`else
        if (corrupt) streamQ.push_back(8'h00);
`endif
    endtask

    // Reference model: expected writes and final outcome from the stream contents.
    task automatic buildExpected();
        int          n;
        logic [31:0] word;
        logic [7:0]  x;
        expQ.delete();
        n = (streamQ[0] == 8'd0) ? 256 : int'(streamQ[0]);
        x = 8'd0;
        for (int k = 0; k < n; k++) begin
            word = 32'(streamQ[1 + 4*k]) * 32'd16777216
                 + 32'(streamQ[2 + 4*k]) * 32'd65536
                 + 32'(streamQ[3 + 4*k]) * 32'd256
                 + 32'(streamQ[4 + 4*k]);
            expQ.push_back({8'(k), word});
            for (int j = 1; j <= 4; j++) x = x ^ streamQ[j + 4*k];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        expOk = (streamQ[1 + 4*n] == x);
`else
        expOk = 1'b1;
`endif
    endtask

    // Drives the whole stream with random idle gaps in [gapMin, gapMax].
    task automatic applyStimulus(input int gapMin, input int gapMax);
        readyLow    = 0;
        earlyStatus = 0;
        for (int i = 0; i < streamQ.size(); i++) begin
            sendByte(streamQ[i], int'($urandom_range(gapMax, gapMin)));
            if (i < streamQ.size() - 1) begin
                if (done_o !== 1'b0 || err_o !== 1'b0 || cpu_start_o !== 1'b0) earlyStatus++;
            end
        end
    endtask

    task automatic runAndCheck(input string tag, input int gapMin, input int gapMax);
        int nWrites;
        buildExpected();
        applyStimulus(gapMin, gapMax);
        checkOutput({tag, ".readyDuringLoad"}, readyLow,    0);
        checkOutput({tag, ".earlyStatus"},     earlyStatus, 0);
        checkOutput({tag, ".cpu"},   cpu_start_o, expOk ? 1 : 0);
        checkOutput({tag, ".done"},  done_o,      expOk ? 1 : 0);
        checkOutput({tag, ".err"},   err_o,       expOk ? 0 : 1);
        checkOutput({tag, ".ready"}, ready_o,     0);
        waitEdge();
        checkOutput({tag, ".writeCount"}, obsQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < obsQ.size()) begin
                checkOutput($sformatf("%s.write%0d", tag, i), obsQ[i], expQ[i]);
            end
        end
        nWrites = obsQ.size();
        sendByte(8'($urandom), 0);
        sendByte(8'($urandom), 1);
        waitEdge();
        checkOutput({tag, ".ignoredInput"}, obsQ.size(), nWrites);
        checkOutput({tag, ".heldDone"},     done_o, expOk ? 1 : 0);
        checkOutput({tag, ".heldErr"},      err_o,  expOk ? 0 : 1);
    endtask

    initial begin
        start_i = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'd0;
        waitEdge();
        doReset();
        checkReset("reset");

        // Two-word directed load with valid held high.
        streamQ = {8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        addChecksum(0);
        runAndCheck("twoWords", 0, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum must end in the error state.
        doReset();
        streamQ = {8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
        runAndCheck("badCsum", 0, 0);
`endif

        // Count byte zero means a full 256-word image.
        doReset();
        streamQ = {8'h00};
        for (int i = 0; i < 1024; i++) streamQ.push_back(8'($urandom));
        addChecksum(0);
        runAndCheck("full256", 0, 0);
        checkOutput("full256.lastAddr", mem_addr_o, 8'd255);

        // Reset on the edge that would complete a word suppresses that write.
        doReset();
        streamQ = {8'h01, 8'hAA, 8'hBB, 8'hCC};
        foreach (streamQ[i]) sendByte(streamQ[i], 0);
        start_i = 1'b0;
        data_i  = 8'hDD;
        valid_i = 1'b1;
        waitEdge();
        start_i = 1'b1;
        valid_i = 1'b0;
        checkOutput("pendingWrite.we", mem_we_o, 0);
        waitEdge();
        checkOutput("pendingWrite.count", obsQ.size(), 0);
        checkReset("pendingWrite");

        // Mid-load reset with a simultaneous byte; partial bytes must vanish.
        doReset();
        streamQ = {8'h01, 8'hAA, 8'hBB};
        foreach (streamQ[i]) sendByte(streamQ[i], 0);
        start_i = 1'b0;
        data_i  = 8'hCC;
        valid_i = 1'b1;
        waitEdge();
        start_i = 1'b1;
        valid_i = 1'b0;
        checkReset("midReset");
        streamQ = {8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        addChecksum(0);
        runAndCheck("afterReset", 0, 0);

        // Three idle cycles before every byte.
        doReset();
        streamQ = {8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        addChecksum(0);
        runAndCheck("gaps", 3, 3);

        // Random loads with random gaps and occasionally corrupted checksums.
        for (int t = 0; t < 6; t++) begin
            int n;
            doReset();
            n = int'($urandom_range(12, 1));
            streamQ = {8'(n)};
            for (int i = 0; i < 4*n; i++) streamQ.push_back(8'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
            addChecksum($urandom_range(2, 0) == 0);
`else
            addChecksum(0);
`endif
            runAndCheck($sformatf("rand%0d", t), 0, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have the ports, one per line (name  direction  width  meaning):
- clk_i  input  1  the single clock; all state changes on its rising edge.
- start_i  input  1  reset; synchronous, active-low; sampled on the rising edge of clk_i.
- data_i  input  8  loader byte stream.
- valid_i  input  1  data_i holds a byte.
- ready_o  output  1  block accepts a byte this cycle.
- mem_we_o  output  1  instruction-memory write strobe, one cycle wide.
- mem_addr_o  output  8  instruction-memory word index (0..255).
- mem_data_o  output  32  instruction word to write.
- cpu_start_o  output  1  drives CPU start_i; high only after a successful load.
- done_o  output  1  load completed successfully.
- err_o  output  1  load failed.

Function
REQ-002 A byte SHALL be accepted on a rising clk_i edge where valid_i=1 and ready_o=1; no other edge consumes data_i.
REQ-003 The block SHALL implement the states S_LEN, S_DATA, S_CSUM, S_RUN and S_ERR; reset enters S_LEN.
REQ-004 ready_o SHALL be 1 in S_LEN, S_DATA and S_CSUM, and 0 in S_RUN and S_ERR.
REQ-005 In S_LEN, the accepted byte SHALL set the word count N: byte value 0 means N=256, otherwise N equals the value; the state moves to S_DATA.
REQ-006 In S_DATA, bytes SHALL be assembled big-endian: the first byte forms bits [31:24] and the fourth byte forms bits [7:0].
REQ-007 On the edge that accepts the 4th byte of word k, the block SHALL register mem_we_o=1, mem_addr_o=k and mem_data_o=the assembled word; mem_we_o returns to 0 on the next edge unless another word completes.
REQ-008 The word index k SHALL start at 0, increment by 1 per written word, and never exceed 255 (8-bit, no wrap observable).
REQ-009 After word N-1 is accepted, the next state SHALL be S_CSUM if CHECKSUM is compiled in, else S_RUN.
REQ-010 Gaps in valid_i (valid_i=0 for any number of cycles) SHALL pause assembly without loss or corruption of partial words.
REQ-011 In S_RUN: cpu_start_o=1 and done_o=1, held until reset; further input SHALL be ignored.
REQ-012 In S_ERR: err_o=1, cpu_start_o=0 and done_o=0, held until reset; no further writes SHALL occur.
REQ-013 cpu_start_o, done_o and err_o SHALL be registered outputs that change on the same edge as the state transition.
REQ-014 mem_we_o SHALL never assert in S_LEN, S_CSUM, S_RUN or S_ERR.

Reset
REQ-015 With start_i=0 at a rising edge, the block SHALL set state=S_LEN, ready_o=1, mem_we_o=0, mem_addr_o=0, mem_data_o=0, cpu_start_o=0, done_o=0, err_o=0, and clear the word index, byte counter, N and the checksum accumulator.
REQ-016 Reset asserted mid-load SHALL discard any partial word and suppress a write pending on that edge; already-written words are not retracted.
REQ-017 Reset SHALL take priority over a simultaneous byte acceptance.

Configuration
REQ-018 The macro IMEM_LOADER_CHECKSUM_EN SHALL select checksum support.
REQ-019 With the macro defined: an 8-bit XOR of all bytes accepted in S_DATA SHALL be accumulated; in S_CSUM the accepted byte is compared to it; on a match the block goes to S_RUN, on a mismatch to S_ERR.
REQ-020 With the macro undefined: S_CSUM, the accumulator and the comparator SHALL be absent, err_o SHALL be tied to 0, and S_DATA goes directly to S_RUN after word N-1.

Verification
REQ-021 Stream 02, 12 34 56 78, 9A BC DE F0 with valid_i held high -> writes (0, 0x12345678) then (1, 0x9ABCDEF0), each one-cycle mem_we_o; cpu_start_o=1 after the final byte (macro off) or after checksum byte 0x00 (macro on).
REQ-022 Macro on, stream 01, 00 00 00 01, checksum 0x02 -> one write (0, 0x00000001), then err_o=1, cpu_start_o stays 0, ready_o=0.
REQ-023 Count byte 00 followed by 1024 bytes -> 256 writes at addresses 0..255, with mem_addr_o=255 on the last; then done_o=1.
REQ-024 Stream 01, AA BB with start_i pulsed low for one edge, then 01, 11 22 33 44 -> single write (0, 0x11223344); the bytes AA BB never appear in any write.
REQ-025 Stream 01, DE AD BE EF with valid_i low for 3 cycles between every byte -> single write (0, 0xDEADBEEF); ready_o stays 1 throughout the load.
